// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one SEG-wide carry segment resolved per stage,
// valid/ready flow control with a global stall on downstream backpressure.
module adder_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    logic             vld_q [STAGES];
    logic [WIDTH-1:0] dat_q [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];
    logic             cry_q [STAGES];
    logic             am_q  [STAGES];
    logic             bm_q  [STAGES];

    logic             src_v  [STAGES];
    logic [WIDTH-1:0] src_d  [STAGES];
    logic [WIDTH-1:0] src_b  [STAGES];
    logic             src_c  [STAGES];
    logic             src_am [STAGES];
    logic             src_bm [STAGES];
    logic [SEG:0]     seg_sum [STAGES];
    logic [WIDTH-1:0] nxt_d  [STAGES];

    assign b_eff    = b_in ^ {WIDTH{sub_in}};
    assign c_eff    = carry_in ^ sub_in;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;
    assign accept   = in_valid && in_ready;

    // dat carries finished sum bits below the active segment and A above it
    always_comb begin
        src_v[0]  = accept;
        src_d[0]  = a_in;
        src_b[0]  = b_eff;
        src_c[0]  = c_eff;
        src_am[0] = a_in[WIDTH-1];
        src_bm[0] = b_eff[WIDTH-1];
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]  = vld_q[k-1];
            src_d[k]  = dat_q[k-1];
            src_b[k]  = opb_q[k-1];
            src_c[k]  = cry_q[k-1];
            src_am[k] = am_q[k-1];
            src_bm[k] = bm_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_sum[k] = {1'b0, src_d[k][k*SEG +: SEG]}
                       + {1'b0, src_b[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, src_c[k]};
            nxt_d[k] = src_d[k];
            nxt_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
        end
    end

    // Bubbles only clear the valid bit so that data (and outputs) stay put
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= '0;
                opb_q[k] <= '0;
                cry_q[k] <= 1'b0;
                am_q[k]  <= 1'b0;
                bm_q[k]  <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= src_v[k];
                if (src_v[k]) begin
                    dat_q[k] <= nxt_d[k];
                    opb_q[k] <= src_b[k];
                    cry_q[k] <= seg_sum[k][SEG];
                    am_q[k]  <= src_am[k];
                    bm_q[k]  <= src_bm[k];
                end
            end
        end
    end

    assign out_valid    = vld_q[LAST];
    assign sum_out      = dat_q[LAST];
    assign carry_out    = cry_q[LAST];
    assign overflow_out = (am_q[LAST] == bm_q[LAST])
                       && (dat_q[LAST][WIDTH-1] != am_q[LAST]);

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: cycle-exact checks on the 64/4 build, with
// 8/1 and 16/8 builds run on the same stimulus against per-instance scoreboards.
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;

    logic        in_ready0, out_valid0, c0, o0;
    logic [63:0] sum0;
    logic        in_ready1, out_valid1, c1, o1;
    logic [7:0]  sum1;
    logic        in_ready2, out_valid2, c2, o2;
    logic [15:0] sum2;

    int n_cmp = 0;
    int n_err = 0;

    logic [65:0] q0[$];
    logic [65:0] q1[$];
    logic [65:0] q2[$];
    logic [65:0] ex[8];

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(64), .STAGES(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a_in(a), .b_in(b), .carry_in(cin), .sub_in(sub),
        .out_valid(out_valid0), .out_ready(out_ready), .sum_out(sum0),
        .carry_out(c0), .overflow_out(o0)
    );

    adder_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a_in(a[7:0]), .b_in(b[7:0]), .carry_in(cin), .sub_in(sub),
        .out_valid(out_valid1), .out_ready(out_ready), .sum_out(sum1),
        .carry_out(c1), .overflow_out(o1)
    );

    adder_pipe #(.WIDTH(16), .STAGES(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a_in(a[15:0]), .b_in(b[15:0]), .carry_in(cin), .sub_in(sub),
        .out_valid(out_valid2), .out_ready(out_ready), .sum_out(sum2),
        .carry_out(c2), .overflow_out(o2)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, sum} packed at bit positions w+1, w, w-1:0
    function automatic logic [65:0] model(input logic [63:0] ta,
                                          input logic [63:0] tb,
                                          input logic ci, input logic sb,
                                          input int w);
        logic [64:0] m, am, be, full;
        logic [65:0] r;
        m    = (65'd1 << w) - 65'd1;
        am   = {1'b0, ta} & m;
        be   = {1'b0, (sb ? ~tb : tb)} & m;
        full = am + be + {64'd0, ci ^ sb};
        r    = {1'b0, full & m};
        r[w]   = full[w];
        r[w+1] = (am[w-1] == be[w-1]) && (full[w-1] != am[w-1]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (out_valid0 === 1'b1 && out_ready) begin
            if (q0.size() == 0) chk("d0_spurious", 128'(out_valid0), 128'd0);
            else chk("d0_result", {o0, c0, sum0}, q0.pop_front());
        end
        if (rst) q0.delete();
        else if (in_valid && in_ready0) q0.push_back(model(a, b, cin, sub, 64));
    end

    always @(negedge clk) begin
        if (out_valid1 === 1'b1 && out_ready) begin
            if (q1.size() == 0) chk("d1_spurious", 128'(out_valid1), 128'd0);
            else chk("d1_result", {o1, c1, sum1}, q1.pop_front());
        end
        if (rst) q1.delete();
        else if (in_valid && in_ready1) q1.push_back(model(a, b, cin, sub, 8));
    end

    always @(negedge clk) begin
        if (out_valid2 === 1'b1 && out_ready) begin
            if (q2.size() == 0) chk("d2_spurious", 128'(out_valid2), 128'd0);
            else chk("d2_result", {o2, c2, sum2}, q2.pop_front());
        end
        if (rst) q2.delete();
        else if (in_valid && in_ready2) q2.push_back(model(a, b, cin, sub, 16));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand(output logic [65:0] e);
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        e   = model(a, b, cin, sub, 64);
    endtask

    // One isolated operation on the 64/4 build, latency checked exactly
    task automatic run1(input string tag, input logic [63:0] ta,
                        input logic [63:0] tb, input logic ci,
                        input logic sb, input logic [63:0] es,
                        input logic ec, input logic eo);
        a = ta; b = tb; cin = ci; sub = sb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk({tag, "_early"}, 128'(out_valid0), 128'd0);
        tick();
        chk({tag, "_vld"}, 128'(out_valid0), 128'd1);
        chk({tag, "_sum"}, 128'(sum0), 128'(es));
        chk({tag, "_cout"}, 128'(c0), 128'(ec));
        chk({tag, "_ovf"}, 128'(o0), 128'(eo));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        chk("rst_irdy", 128'(in_ready0), 128'd0);
        chk("rst_vld", 128'(out_valid0), 128'd0);
        chk("rst_sum", 128'(sum0), 128'd0);
        chk("rst_cout", 128'(c0), 128'd0);
        chk("rst_ovf", 128'(o0), 128'd0);
        rst = 1'b0;
        #1;
        chk("irdy", 128'(in_ready0), 128'd1);

        run1("s1", 64'h0000FF00FFFF00FF, 64'h000000FF0000FF00, 1'b0, 1'b0,
             64'h0000FFFFFFFFFFFF, 1'b0, 1'b0);
        run1("s2", 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 1'b0,
             64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
        run1("s3", 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0,
             64'h0, 1'b1, 1'b0);
        run1("s4a", 64'd5, 64'd7, 1'b0, 1'b1,
             64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0);
        run1("s4b", 64'h8000000000000000, 64'd1, 1'b0, 1'b1,
             64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1);

        // 8 back-to-back, one result per cycle in order
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                set_rand(ex[i]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i < 3) begin
                chk("s5_empty", 128'(out_valid0), 128'd0);
            end else begin
                chk("s5_vld", 128'(out_valid0), 128'd1);
                chk("s5_res", {o0, c0, sum0}, ex[i-3]);
            end
        end
        tick();
        chk("s5_drained", 128'(out_valid0), 128'd0);

        // Fill, stall 3 cycles, release
        for (int i = 0; i < 4; i++) begin
            set_rand(ex[i]);
            in_valid = 1'b1;
            tick();
        end
        chk("s5_fill_vld", 128'(out_valid0), 128'd1);
        chk("s5_fill_res", {o0, c0, sum0}, ex[0]);
        out_ready = 1'b0;
        set_rand(ex[4]);
        #1;
        chk("s5_stall_irdy", 128'(in_ready0), 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s5_hold_vld", 128'(out_valid0), 128'd1);
            chk("s5_hold_res", {o0, c0, sum0}, ex[0]);
            chk("s5_hold_irdy", 128'(in_ready0), 128'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("s5_rel_irdy", 128'(in_ready0), 128'd1);
        for (int j = 1; j < 5; j++) begin
            tick();
            in_valid = 1'b0;
            chk("s5_rel_vld", 128'(out_valid0), 128'd1);
            chk("s5_rel_res", {o0, c0, sum0}, ex[j]);
        end
        tick();
        chk("s5_rel_done", 128'(out_valid0), 128'd0);
        repeat (10) tick();

        // Reset with 3 in flight, plus an input offered during reset
        for (int i = 0; i < 3; i++) begin
            set_rand(ex[i]);
            in_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        set_rand(ex[3]);
        #1;
        chk("s6_irdy", 128'(in_ready0), 128'd0);
        tick();
        chk("s6_vld", 128'(out_valid0), 128'd0);
        chk("s6_sum", 128'(sum0), 128'd0);
        chk("s6_cout", 128'(c0), 128'd0);
        chk("s6_ovf", 128'(o0), 128'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s6_gone", 128'(out_valid0), 128'd0);
        end
        run1("s6_add", 64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0);

        repeat (12) tick();
        chk("q0_left", 128'(q0.size()), 128'd0);
        chk("q1_left", 128'(q1.size()), 128'd0);
        chk("q2_left", 128'(q2.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
